// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 game datapath.
// Holds tile encodings, the spawner state type and the LFSR tap table.
package game2048_pkg;

    localparam int N_DEF      = 4;
    localparam int TILE_W_DEF = 12;

    localparam int TILE_EMPTY = 0;
    localparam int TILE_2     = 2;
    localparam int TILE_4     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        PICK  = 3'd2,
        PLACE = 3'd3,
        FIN   = 3'd4
    } spawn_state_t;

    // Galois (right-shift) feedback masks for maximal-length generators.
    // Widths without a table entry fall back to a simple x^w + x + 1 style
    // mask; the zero guard in lfsr_gen keeps such a generator alive.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] mask_s;
        case (w)
            8:       mask_s = 32'h0000_00B8;
            16:      mask_s = 32'h0000_B400;
            24:      mask_s = 32'h00E1_0000;
            32:      mask_s = 32'hA300_0000;
            default: mask_s = (32'h0000_0001 << (w - 1)) | 32'h0000_0001;
        endcase
        return mask_s;
    endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// Request/result bundle between the game FSM (master) and the tile spawner (slave).
interface tile_spawner_if #(
    parameter int N      = 4,
    parameter int TILE_W = 12,
    parameter int LFSR_W = 16
);
    localparam int RC_W = (N > 1) ? $clog2(N) : 1;

    logic                                 start;
    logic                                 seed_load;
    logic [LFSR_W-1:0]                    seed;
    logic [N-1:0][N-1:0][TILE_W-1:0]      board_in;
    logic [N-1:0][N-1:0][TILE_W-1:0]      board_out;
    logic [RC_W-1:0]                      spawn_row;
    logic [RC_W-1:0]                      spawn_col;
    logic [TILE_W-1:0]                    spawn_val;
    logic                                 busy;
    logic                                 done;
    logic                                 full;

    modport master (
        output start, seed_load, seed, board_in,
        input  board_out, spawn_row, spawn_col, spawn_val, busy, done, full
    );

    modport slave (
        input  start, seed_load, seed, board_in,
        output board_out, spawn_row, spawn_col, spawn_val, busy, done, full
    );

endinterface

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR with synchronous load and a zero-state guard.
// A load value of zero, or the generator ever reaching zero, reloads SEED.
module lfsr_gen #(
    parameter int           W    = 16,
    parameter logic [W-1:0] SEED = W'(32'h0000_ACE1),
    parameter logic [W-1:0] TAPS = W'(32'h0000_B400)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    logic [W-1:0] lfsr_r;
    logic [W-1:0] next_s;
    logic [W-1:0] load_s;

    // Next-state: one Galois step, or SEED if the register has collapsed to zero.
    always_comb begin
        next_s = lfsr_r >> 1;
        if (lfsr_r == {W{1'b0}}) begin
            next_s = SEED;
        end else if (lfsr_r[0]) begin
            next_s = (lfsr_r >> 1) ^ TAPS;
        end else begin
            next_s = lfsr_r >> 1;
        end
    end

    // Load value selection: zero is never allowed into the register.
    always_comb begin
        if (load_val == {W{1'b0}}) begin
            load_s = SEED;
        end else begin
            load_s = load_val;
        end
    end

    // State register: load has priority over stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else if (load) begin
            lfsr_r <= load_s;
        end else begin
            lfsr_r <= next_s;
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/tile_spawner.sv
// Random tile spawner for the 2048 board.
// On start it snapshots the board, counts empty cells, picks one of them
// uniformly from the snapshotted LFSR value and writes a 2 or a 4 into it.
// A board without empty cells completes with full set and the board untouched.
module tile_spawner
    import game2048_pkg::*;
#(
    parameter int                N       = N_DEF,
    parameter int                TILE_W  = TILE_W_DEF,
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(32'h0000_ACE1),
    parameter int                FOUR_TH = 2
) (
    input logic           clk,
    input logic           rst,
    tile_spawner_if.slave bus
);

    localparam int CELLS  = N * N;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int RC_W   = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W = 8 + CNT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    // Random source, shared design with the AI/demo player.
    logic [LFSR_W-1:0] lfsr_s;

    lfsr_gen #(
        .W    (LFSR_W),
        .SEED (SEED),
        .TAPS (LFSR_W'(lfsr_taps(LFSR_W)))
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.seed_load),
        .load_val (bus.seed),
        .state    (lfsr_s)
    );

    // Working state. The board is held flat so idx = row*N + col addresses it directly.
    spawn_state_t                   state_r;
    logic [CELLS-1:0][TILE_W-1:0]   board_r;
    logic [LFSR_W-1:0]              r_r;
    logic [IDX_W-1:0]               idx_r;
    logic [CNT_W-1:0]               cnt_r;
    logic [CNT_W-1:0]               run_r;
    logic [CNT_W-1:0]               tgt_r;
    logic [TILE_W-1:0]              val_r;
    logic                           nocell_r;

    // Registered outputs.
    logic [CELLS-1:0][TILE_W-1:0]   board_out_r;
    logic [RC_W-1:0]                spawn_row_r;
    logic [RC_W-1:0]                spawn_col_r;
    logic [TILE_W-1:0]              spawn_val_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           full_r;

    // Decoded views of the current cell and the pick arithmetic.
    logic [TILE_W-1:0]              cell_s;
    logic                           cell_empty_s;
    logic [RC_W-1:0]                row_s;
    logic [RC_W-1:0]                col_s;
    logic [PROD_W-1:0]              prod_s;
    logic [CNT_W-1:0]               tgt_s;
    logic [TILE_W-1:0]              val_s;

    // Cell decode, coordinate split and scaled target: top byte * cnt / 256 is in 0..cnt-1.
    always_comb begin
        cell_s       = board_r[idx_r];
        cell_empty_s = (cell_s == TILE_W'(TILE_EMPTY));
        row_s        = RC_W'(int'(idx_r) / N);
        col_s        = RC_W'(int'(idx_r) % N);
        prod_s       = PROD_W'(r_r[LFSR_W-1 -: 8]) * PROD_W'(cnt_r);
        tgt_s        = prod_s[8 +: CNT_W];
        if (r_r[3:0] < 4'(FOUR_TH)) begin
            val_s = TILE_W'(TILE_4);
        end else begin
            val_s = TILE_W'(TILE_2);
        end
    end

    // Spawn sequencer: IDLE -> SCAN -> PICK -> (PLACE) -> FIN -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            board_r     <= '{default: {TILE_W{1'b0}}};
            r_r         <= {LFSR_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            run_r       <= {CNT_W{1'b0}};
            tgt_r       <= {CNT_W{1'b0}};
            val_r       <= {TILE_W{1'b0}};
            nocell_r    <= 1'b0;
            board_out_r <= '{default: {TILE_W{1'b0}}};
            spawn_row_r <= {RC_W{1'b0}};
            spawn_col_r <= {RC_W{1'b0}};
            spawn_val_r <= {TILE_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            full_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        board_r <= bus.board_in;
                        r_r     <= lfsr_s;
                        busy_r  <= 1'b1;
                        full_r  <= 1'b0;
                        idx_r   <= {IDX_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= SCAN;
                    end
                end
                SCAN: begin
                    if (cell_empty_s) begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= PICK;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1'b1);
                    end
                end
                PICK: begin
                    idx_r <= {IDX_W{1'b0}};
                    run_r <= {CNT_W{1'b0}};
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        nocell_r <= 1'b1;
                        state_r  <= FIN;
                    end else begin
                        nocell_r <= 1'b0;
                        tgt_r    <= tgt_s;
                        val_r    <= val_s;
                        state_r  <= PLACE;
                    end
                end
                PLACE: begin
                    if (cell_empty_s && (run_r == tgt_r)) begin
                        board_r[idx_r] <= val_r;
                        spawn_row_r    <= row_s;
                        spawn_col_r    <= col_s;
                        spawn_val_r    <= val_r;
                        state_r        <= FIN;
                    end else begin
                        if (cell_empty_s) begin
                            run_r <= run_r + CNT_W'(1'b1);
                        end
                        // The target always exists; the last-cell exit only guards against corruption.
                        if (idx_r == LAST_IDX) begin
                            state_r <= FIN;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1'b1);
                        end
                    end
                end
                FIN: begin
                    board_out_r <= board_r;
                    full_r      <= nocell_r;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.board_out = board_out_r;
    assign bus.spawn_row = spawn_row_r;
    assign bus.spawn_col = spawn_col_r;
    assign bus.spawn_val = spawn_val_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.full      = full_r;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: a transaction-level model predicts the
// chosen cell, value and completion cycle of each spawn; a compare process
// checks every DUT output against it on every cycle.
module tb_tile_spawner;
    import game2048_pkg::*;

    localparam int N       = 4;
    localparam int TW      = 12;
    localparam int LW      = 16;
    localparam int CELLS   = N * N;
    localparam int FOUR_TH = 2;
    localparam logic [LW-1:0] SEED = 16'hACE1;

    typedef logic [N-1:0][N-1:0][TW-1:0] board_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_spawner_if #(.N(N), .TILE_W(TW), .LFSR_W(LW)) bus ();

    tile_spawner #(.N(N), .TILE_W(TW), .LFSR_W(LW), .SEED(SEED), .FOUR_TH(FOUR_TH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // ---------------- model state ----------------
    logic [LW-1:0] m_lfsr  = SEED;
    bit            m_busy  = 1'b0;
    bit            m_done  = 1'b0;
    bit            m_full  = 1'b0;
    board_t        m_board = '0;
    int            m_row   = 0;
    int            m_col   = 0;
    int            m_val   = 0;
    int            m_n     = 0;
    int            acc_cyc = 0;
    // prediction for the operation in flight
    board_t        p_board;
    bit            p_full;
    int            p_row, p_col, p_val, p_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_board(input string name, input board_t act, input board_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s);
        if (s == '0) return SEED;
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Outcome of a spawn from the board snapshot and random word, straight from the rules.
    task automatic predict(input board_t b, input logic [LW-1:0] r);
        int empt[$];
        int cnt, tgt, k, v;
        for (int i = 0; i < CELLS; i++)
            if (b[i / N][i % N] == '0) empt.push_back(i);
        cnt     = empt.size();
        p_board = b;
        if (cnt == 0) begin
            p_full = 1'b1;
            p_d    = (CELLS + 3) - 1;
        end else begin
            tgt    = (int'(r[LW-1 -: 8]) * cnt) >> 8;
            v      = (int'(r[3:0]) < FOUR_TH) ? 4 : 2;
            k      = empt[tgt];
            p_full = 1'b0;
            p_d    = (CELLS + 3 + (k + 1)) - 1;
            p_board[k / N][k % N] = TW'(v);
            p_row  = k / N;
            p_col  = k % N;
            p_val  = v;
        end
    endtask

    // Model: advances once per clock edge using the inputs the DUT sees.
    initial begin
        logic [LW-1:0] lr;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_lfsr = SEED; m_busy = 0; m_done = 0; m_full = 0; m_board = '0;
                m_row = 0; m_col = 0; m_val = 0; m_n = 0;
            end else begin
                lr = m_lfsr;
                if (bus.seed_load) m_lfsr = (bus.seed == '0) ? SEED : bus.seed;
                else               m_lfsr = lfsr_step(m_lfsr);
                m_done = 0;
                if (!m_busy) begin
                    if (bus.start) begin
                        predict(bus.board_in, lr);
                        m_busy = 1; m_full = 0; m_n = 0; acc_cyc = cyc;
                    end
                end else begin
                    m_n++;
                    if (!p_full && m_n == p_d - 1) begin
                        m_row = p_row; m_col = p_col; m_val = p_val;
                    end
                    if (m_n == p_d) begin
                        m_busy = 0; m_done = 1; m_board = p_board; m_full = p_full;
                    end
                end
            end
        end
    end

    // Compare process: every output, every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 64'(bus.busy), 64'(m_busy));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("full", 64'(bus.full), 64'(m_full));
            chk("spawn_row", 64'(bus.spawn_row), 64'(m_row));
            chk("spawn_col", 64'(bus.spawn_col), 64'(m_col));
            chk("spawn_val", 64'(bus.spawn_val), 64'(m_val));
            chk_board("board_out", bus.board_out, m_board);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = cyc - acc_cyc + 1;
                break;
            end
        end
        if (lat < 0) begin
            tests++; fails++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        #1;
    endtask

    function automatic int nonzero(input board_t b);
        int c = 0;
        for (int i = 0; i < CELLS; i++) if (b[i / N][i % N] != '0) c++;
        return c;
    endfunction

    // Spawn right after reset: LFSR = ACE1 -> tgt 10 = cell (2,2), value 4, latency 30.
    task automatic spawn_after_reset(input string tag);
        int lat;
        rst = 1'b0; start_pulse_board('0);
        wait_done(50, lat);
        chk({tag, "_latency"}, 64'(lat), 64'd30);
        chk({tag, "_row"}, 64'(bus.spawn_row), 64'd2);
        chk({tag, "_col"}, 64'(bus.spawn_col), 64'd2);
        chk({tag, "_val"}, 64'(bus.spawn_val), 64'd4);
    endtask

    task automatic start_pulse_board(input board_t b);
        bus.board_in = b;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    initial begin
        board_t b;
        int lat, nd, fours, ok;
        int hits[CELLS];

        rst = 1'b1;
        bus.start = 1'b0; bus.seed_load = 1'b0; bus.seed = '0; bus.board_in = '0;
        tick(); tick(); tick();
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk_board("reset_board", bus.board_out, '0);

        // First spawn out of reset pins the SEED value.
        bus.start = 1'b1; rst = 1'b0; bus.board_in = '0;
        tick(); bus.start = 1'b0;
        wait_done(50, lat);
        chk("first_latency", 64'(lat), 64'd30);
        chk("first_row", 64'(bus.spawn_row), 64'd2);
        chk("first_col", 64'(bus.spawn_col), 64'd2);
        chk("first_val", 64'(bus.spawn_val), 64'd4);

        // Seed 0001: top byte 0 -> cell 0, low nibble 1 -> value 4, latency 20.
        bus.seed_load = 1'b1; bus.seed = 16'h0001;
        tick();
        bus.seed_load = 1'b0;
        start_pulse_board('0);
        wait_done(2 * CELLS + 3 + 2, lat);
        chk("seed1_latency", 64'(lat), 64'd20);
        chk("seed1_nonzero", 64'(nonzero(bus.board_out)), 64'd1);
        chk("seed1_cell", 64'(bus.board_out[bus.spawn_row][bus.spawn_col]), 64'(bus.spawn_val));
        chk("seed1_val", 64'(bus.spawn_val), 64'd4);

        // Only (3,1) empty: index 13, latency 33.
        for (int i = 0; i < CELLS; i++) b[i / N][i % N] = TW'(2 * (i + 1));
        b[3][1] = '0;
        start_pulse_board(b);
        wait_done(50, lat);
        chk("one_empty_latency", 64'(lat), 64'd33);
        chk("one_empty_row", 64'(bus.spawn_row), 64'd3);
        chk("one_empty_col", 64'(bus.spawn_col), 64'd1);
        ok = 1;
        for (int i = 0; i < CELLS; i++)
            if (i != 13 && bus.board_out[i / N][i % N] != TW'(2 * (i + 1))) ok = 0;
        chk("one_empty_others_kept", 64'(ok), 64'd1);

        // Full board: no write, full with done at 19.
        for (int i = 0; i < CELLS; i++) b[i / N][i % N] = TW'(2);
        start_pulse_board(b);
        wait_done(50, lat);
        chk("full_latency", 64'(lat), 64'd19);
        chk("full_flag", 64'(bus.full), 64'd1);
        chk_board("full_board", bus.board_out, b);

        // start pulses while busy are ignored.
        start_pulse_board('0);
        nd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
            #1;
            bus.start = (i == 5 || i == 12);
            bus.board_in = (i == 5) ? b : '0;
        end
        bus.start = 1'b0; bus.board_in = '0;
        chk("busy_start_done_count", 64'(nd), 64'd1);
        chk("busy_start_one_tile", 64'(nonzero(bus.board_out)), 64'd1);

        // Reset mid-SCAN aborts with no done.
        start_pulse_board('0);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
            #1;
        end
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_done_count", 64'(nd), 64'd0);
        chk_board("midreset_board", bus.board_out, '0);
        bus.start = 1'b1; rst = 1'b0;
        tick(); bus.start = 1'b0;
        wait_done(50, lat);
        chk("midreset_latency", 64'(lat), 64'd30);
        chk("midreset_row", 64'(bus.spawn_row), 64'd2);
        chk("midreset_col", 64'(bus.spawn_col), 64'd2);

        // Back-to-back spawns with start held high.
        for (int i = 0; i < CELLS; i++) hits[i] = 0;
        fours = 0;
        bus.board_in = '0; bus.start = 1'b1;
        for (int s = 0; s < 300; s++) begin
            wait_done(45, lat);
            if (lat >= 0) begin
                hits[int'(bus.spawn_row) * N + int'(bus.spawn_col)]++;
                if (bus.spawn_val == TW'(4)) fours++;
            end
        end
        bus.start = 1'b0;
        tick(); tick();
        ok = 1;
        for (int i = 0; i < CELLS; i++) if (hits[i] == 0) ok = 0;
        chk("stats_every_cell_hit", 64'(ok), 64'd1);
        chk("stats_fours_in_range", 64'((fours >= 10) && (fours <= 80)), 64'd1);

        for (int i = 0; i < 40; i++) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
